seq_array_divider: RTL and testbench
====================================

Name: seq_array_divider

Overview:
- Sequential restoring divider that inverts the team's 4x4 array multiplier.
- Takes a 2N-bit dividend (a multiplier product) and an N-bit divisor; returns a 2N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the same Tiny Tapeout top, for round-trip checks (a*b)/b == a.

Parameters:
- N, 4, divisor width; dividend and quotient are 2N bits wide.

Ports:
- clk  input  1  single system clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  2N  numerator; captured on the accepting edge.
- divisor  input  N  denominator; captured on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  single-cycle pulse; results are valid from this cycle.
- quotient  output  2N  result; held until the next accepted start.
- remainder  output  N  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor == 0; held with the results.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal operand and partial registers are cleared. Reset overrides start and aborts any operation in flight, with no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0, iteration counter 0..2N-1.
  - DONE: busy=0, done=1, for exactly one cycle; always returns to IDLE.
- Accept: in IDLE with start=1 at an edge, capture the operands.
  - If divisor != 0: go to RUN with count=0, partial remainder P (N+1 bits) = 0, and the shift register loaded with dividend.
  - If divisor == 0: go straight to DONE with quotient = all ones (2N'b1...1), remainder = 0, div_by_zero = 1.
- RUN iteration, once per edge, MSB of the dividend first:
  - P' = {P[N-1:0], dividend_msb}.
  - If P' >= {0,divisor}: P = P' - divisor and qbit = 1. Otherwise P = P' and qbit = 0.
  - Shift qbit into the quotient register LSB.
  - After 2N iterations (count == 2N-1), go to DONE with quotient = shift register and remainder = P[N-1:0], div_by_zero = 0.
- Latency:
  - start high in cycle 0 → busy high in cycles 1..2N → done high in cycle 2N+1. For N=4, done is in cycle 9.
  - Divide-by-zero: done in cycle 1.
- Output update rules:
  - quotient, remainder and div_by_zero change only on the edge entering DONE; they are stable across RUN and IDLE.
  - busy and done are never high together.
- start during RUN or DONE is ignored: not queued, no effect. start held high continuously begins a new division in the first IDLE cycle, i.e. back-to-back period 2N+2 cycles.
- Changes on dividend or divisor after the accepting edge have no effect on the running operation.
- Arithmetic invariant: dividend == quotient*divisor + remainder and remainder < divisor, for all divisor != 0. The quotient can reach 2^(2N)-1 when divisor = 1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0. With start=0 for 20 cycles → busy=0 and done=0 throughout.
- Basic divisions (N=4), checked one at a time:
  - 143/11 → quotient 13, remainder 0, done in cycle 9, busy high in cycles 1-8.
  - 200/7 → 28 r 4.
  - 255/1 → 255 r 0.
  - 0/5 → 0 r 0.
- Divide-by-zero: dividend=77, divisor=0 → done in cycle 1, quotient=255, remainder=0, div_by_zero=1. The next valid division clears div_by_zero at its done.
- Handshake robustness:
  - Pulse start with 225/15; in cycle 4 pulse start with 100/3 and also change the dividend/divisor inputs → done once with 15 r 0. The second request is ignored.
  - Holding start high produces done pulses every 10 cycles.
- Reset mid-operation: start 143/11, assert rst in cycle 5 → next cycle busy=0, done=0, quotient=0. No done pulse follows. A fresh 143/11 then completes normally.
- Multiplier round-trip sweep: for all a,b in 0..15 with b != 0, divide a*b by b → quotient==a, remainder==0. Random dividend/divisor for 1000 runs → invariant holds.

Source files
------------

// File: rtl/seq_array_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, MSB first. Start/busy/done handshake; results are held until
// the next accepted start. Intended to undo the 4x4 array multiplier.
module seq_array_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero
);

  localparam int W  = 2 * N;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   dvs;     // captured divisor
  logic [W-1:0]   sr;      // dividend bits shift out the top, quotient bits in at the bottom
  logic [N-1:0]   p;       // partial remainder, always < divisor so N bits suffice

  logic [N:0]     p_shift;
  logic [N:0]     diff;
  logic           qbit;
  logic [N-1:0]   p_next;

  // One restoring step. Since p < dvs, p_shift <= 2*dvs-1, so p_shift - dvs
  // lies in (-2^N, 2^N): the top bit of the (N+1)-bit difference is exactly
  // the borrow, i.e. it is clear iff p_shift >= dvs.
  always_comb begin
    p_shift = {p, sr[W-1]};
    diff    = p_shift - {1'b0, dvs};
    qbit    = ~diff[N];
    p_next  = qbit ? diff[N-1:0] : p_shift[N-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; busy and done decode disjoint states.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (divisor == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration, and result registers (updated only on the
  // edge that enters DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvs         <= '0;
      sr          <= '0;
      p           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvs <= divisor;
            sr  <= dividend;
            p   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          sr  <= {sr[W-2:0], qbit};
          p   <= p_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient    <= {sr[W-2:0], qbit};
            remainder   <= p_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_divider.sv
// Scoreboard bench for seq_array_divider (N=4): expected results are queued
// when a request is driven and compared whenever done pulses.
module tb_seq_array_divider;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient;
  logic [N-1:0] remainder;

  seq_array_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a; e.b = b;
    if (b == 0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued request.
  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) chk("busy_done_exclusive", 1, 0);
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        if (e.b != 0) begin
          chk("invariant_sum", quotient * e.b + remainder, e.a);
          chk("invariant_rem_lt", remainder < e.b, 1);
        end
      end
    end
  end

  // One division from IDLE: checks done latency, busy through RUN, and that
  // the results hold still while running. Inputs are scrambled after accept.
  task automatic run_div(input logic [W-1:0] a, input logic [N-1:0] b);
    int cyc;
    bit got, busy_ok, qchg;
    logic [W-1:0] q0;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = N'($urandom);
    cyc = 1; got = 0; busy_ok = 1; qchg = 0; q0 = quotient;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (quotient !== q0) qchg = 1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk("done_latency", cyc, (b == 0) ? 1 : W + 1);
      chk("busy_in_run", busy_ok, 1);
      chk("quotient_stable_run", qchg, 0);
    end
  endtask

  initial begin
    int dcnt, dcyc, last;
    bit bad;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

    // Reset, then a quiet idle period.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1; rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) bad = 1;
    end
    chk("idle_quiet", bad, 0);

    // Basic divisions and divide-by-zero.
    run_div(8'd143, 4'd11);
    run_div(8'd200, 4'd7);
    run_div(8'd255, 4'd1);
    run_div(8'd0,   4'd5);
    run_div(8'd77,  4'd0);
    run_div(8'd143, 4'd11);   // clears div_by_zero

    // Second start during RUN is ignored.
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd225; divisor = 4'd15;
    sb.push_back(model(8'd225, 4'd15));
    dcnt = 0; dcyc = -1;
    for (int c = 0; c < 22; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 4) begin start = 1'b1; dividend = 8'd100; divisor = 4'd3; end
      if (c == 5) begin start = 1'b0; dividend = 8'd9; divisor = 4'd2; end
      @(negedge clk);
      if (done) begin dcnt++; dcyc = c; end
      @(posedge clk); #1;
    end
    chk("ignored_start_done_count", dcnt, 1);
    chk("ignored_start_done_cycle", dcyc, 9);

    // start held high: back-to-back divisions every 2N+2 cycles.
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    repeat (3) sb.push_back(model(8'd200, 4'd7));
    dcnt = 0; last = -1; bad = 0;
    for (int c = 0; c < 36; c++) begin
      if (c == 25) start = 1'b0;
      @(negedge clk);
      if (done) begin
        if (last >= 0 && c - last != W + 2) bad = 1;
        if (last < 0 && c != W + 1) bad = 1;
        last = c; dcnt++;
      end
      @(posedge clk); #1;
    end
    chk("held_start_done_count", dcnt, 3);
    chk("held_start_period", bad, 0);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; dividend = 8'd143; divisor = 4'd11;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;               // high during cycle 5
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_div(8'd143, 4'd11);

    // Multiplier round trip.
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_div(W'(a * b), N'(b));

    // Random operands.
    for (int i = 0; i < 1000; i++)
      run_div(W'($urandom_range(255, 0)), N'($urandom_range(15, 1)));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
